// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the PCD8544 frame-buffer streamer.
// Holds panel geometry, the two addressing commands sent ahead of each frame,
// the streamer FSM encoding and the Wishbone register offsets (wb_adr_i[4:2]).
package lcd_pkg;

  localparam int LCD_COLS = 84;
  localparam int LCD_ROWS = 6;
  localparam int FB_BYTES = LCD_COLS * LCD_ROWS;
  localparam int FB_AW    = 9;

  localparam logic [7:0] CMD_SET_X = 8'h80;
  localparam logic [7:0] CMD_SET_Y = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD_X = 3'd1,
    ST_CMD_Y = 3'd2,
    ST_RD    = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } lcd_state_e;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_FRAME_CNT = 3'd2;

endpackage

// File: rtl/lcd_fb_ram.sv
// lcd_fb_ram: 512x8 dual-port frame-buffer RAM, synchronous read on both
// ports, read-first (a read and a write to the same address in one cycle
// return the old byte).
//   clk          system clock
//   a_we_i       port A write enable
//   a_addr_i     port A address (Wishbone side), read every cycle
//   a_wdata_i    port A write data
//   a_rdata_o    port A registered read data
//   b_en_i       port B read enable; output holds its last value otherwise
//   b_addr_i     port B address (stream side)
//   b_rdata_o    port B registered read data
// Contents are never reset.
module lcd_fb_ram (
  input  logic       clk,
  input  logic       a_we_i,
  input  logic [8:0] a_addr_i,
  input  logic [7:0] a_wdata_i,
  output logic [7:0] a_rdata_o,
  input  logic       b_en_i,
  input  logic [8:0] b_addr_i,
  output logic [7:0] b_rdata_o
);

  logic [7:0] mem_q [512];
  logic [7:0] a_rdata_q;
  logic [7:0] b_rdata_q;

  // Port A: Wishbone write plus read-first registered read.
  always_ff @(posedge clk) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    a_rdata_q <= mem_q[a_addr_i];
  end

  // Port B: stream read; holding the output keeps tx_data stable under stall.
  always_ff @(posedge clk) begin
    if (b_en_i) begin
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/lcd_fb_streamer.sv
// lcd_fb_streamer: Wishbone-written frame buffer that streams a full-screen
// refresh (set-X, set-Y, then all frame bytes) to the PCD8544 byte shifter.
//   clk, reset           system clock, synchronous active-high reset
//   wb_*                 Wishbone slave; adr[11]=1 frame buffer, 0 registers
//   lcd_rst_done         LCD hardware reset complete (gates frame start)
//   tx_data/tx_dc        byte and data/command flag towards the shifter
//   tx_valid/tx_ready    byte handshake
//   busy                 high in every FSM state except IDLE
module lcd_fb_streamer #(
  parameter int LCD_COLS = lcd_pkg::LCD_COLS,
  parameter int LCD_ROWS = lcd_pkg::LCD_ROWS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        lcd_rst_done,
  output logic [7:0]  tx_data,
  output logic        tx_dc,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);
  import lcd_pkg::*;

  localparam int         FB_N     = LCD_COLS * LCD_ROWS;
  localparam logic [8:0] LAST_IDX = 9'(FB_N - 1);

  // Wishbone decode
  logic       wb_req_s, fb_sel_s, in_range_s, fb_we_s, reg_wr_s, start_wr_s;
  logic [8:0] fb_idx_s;
  logic [2:0] reg_off_s;
  logic [31:0] reg_rdata_s;
  logic       ack_q, rd_fb_q, rd_oob_q, auto_q, pending_q;
  logic [31:0] reg_rdata_q;
  logic [15:0] frame_cnt_q;
  logic [7:0] ram_a_rdata_s, ram_b_rdata_s;

  // FSM
  lcd_state_e state_q, state_d;
  logic [8:0] idx_q, idx_d;
  logic       hs_s, clr_pending_s, cnt_inc_s, ram_b_en_s;
  logic       tx_valid_q, tx_dc_q, busy_q;
  logic [7:0] cmd_q;

  logic unused_s;
  assign unused_s = ^{wb_sel_i, wb_adr_i[31:12], wb_adr_i[1:0], wb_dat_i[31:8]};

  assign wb_req_s   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign fb_sel_s   = wb_adr_i[11];
  assign fb_idx_s   = wb_adr_i[10:2];
  assign in_range_s = (fb_idx_s <= LAST_IDX);
  assign reg_off_s  = wb_adr_i[4:2];
  assign fb_we_s    = wb_req_s & wb_we_i & fb_sel_s & in_range_s;
  assign reg_wr_s   = wb_req_s & wb_we_i & ~fb_sel_s;
  assign start_wr_s = reg_wr_s & (reg_off_s == REG_CTRL) & wb_dat_i[0];

  lcd_fb_ram u_ram (
    .clk       (clk),
    .a_we_i    (fb_we_s),
    .a_addr_i  (fb_idx_s),
    .a_wdata_i (wb_dat_i[7:0]),
    .a_rdata_o (ram_a_rdata_s),
    .b_en_i    (ram_b_en_s),
    .b_addr_i  (idx_q),
    .b_rdata_o (ram_b_rdata_s)
  );

  // Register read mux, captured on the request cycle.
  always_comb begin
    reg_rdata_s = 32'd0;
    case (reg_off_s)
      REG_CTRL:      reg_rdata_s = {30'd0, auto_q, 1'b0};
      REG_STATUS:    reg_rdata_s = {29'd0, pending_q, lcd_rst_done, busy_q};
      REG_FRAME_CNT: reg_rdata_s = {16'd0, frame_cnt_q};
      default:       reg_rdata_s = 32'd0;
    endcase
  end

  // Wishbone ack, read-data capture and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q       <= 1'b0;
      rd_fb_q     <= 1'b0;
      rd_oob_q    <= 1'b0;
      reg_rdata_q <= 32'd0;
      auto_q      <= 1'b0;
      pending_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      ack_q <= wb_cyc_i & wb_stb_i & ~ack_q;
      if (wb_req_s) begin
        rd_fb_q     <= fb_sel_s;
        rd_oob_q    <= ~in_range_s;
        reg_rdata_q <= reg_rdata_s;
      end
      if (reg_wr_s && (reg_off_s == REG_CTRL)) begin
        auto_q <= wb_dat_i[1];
      end
      // A START landing on the launch cycle wins so it is never dropped.
      if (start_wr_s) begin
        pending_q <= 1'b1;
      end else if (clr_pending_s) begin
        pending_q <= 1'b0;
      end
      if (cnt_inc_s) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rd_fb_q ? (rd_oob_q ? 32'd0 : {24'd0, ram_a_rdata_s}) : reg_rdata_q;

  assign hs_s = tx_valid_q & tx_ready;

  // Next-state logic for the refresh sequencer.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    clr_pending_s = 1'b0;
    cnt_inc_s     = 1'b0;
    ram_b_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q && lcd_rst_done) begin
          state_d       = ST_CMD_X;
          clr_pending_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD_X: begin
        if (hs_s) begin
          state_d = ST_CMD_Y;
        end else begin
          state_d = ST_CMD_X;
        end
      end
      ST_CMD_Y: begin
        if (hs_s) begin
          state_d = ST_RD;
          idx_d   = 9'd0;
        end else begin
          state_d = ST_CMD_Y;
        end
      end
      ST_RD: begin
        ram_b_en_s = 1'b1;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        if (hs_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        cnt_inc_s = 1'b1;
        if (auto_q) begin
          state_d = ST_CMD_X;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; stream outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 9'd0;
      tx_valid_q <= 1'b0;
      tx_dc_q    <= 1'b0;
      busy_q     <= 1'b0;
      cmd_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_valid_q <= (state_d == ST_CMD_X) || (state_d == ST_CMD_Y) || (state_d == ST_DATA);
      tx_dc_q    <= (state_d == ST_DATA);
      busy_q     <= (state_d != ST_IDLE);
      cmd_q      <= (state_d == ST_CMD_X) ? CMD_SET_X :
                    (state_d == ST_CMD_Y) ? CMD_SET_Y : 8'h00;
    end
  end

  // Data bytes come straight from the registered RAM port, which holds under stall.
  assign tx_data  = (state_q == ST_DATA) ? ram_b_rdata_s : cmd_q;
  assign tx_dc    = tx_dc_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lcd_fb_streamer.sv
// Self-checking bench for lcd_fb_streamer: a byte-array model of the frame
// buffer predicts the expected stream (set-X, set-Y, then every byte in order).
module tb_lcd_fb_streamer;

  localparam int NB = 504;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_adr = 32'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [31:0] wb_dat_o;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0, wb_ack;
  logic        lcd_rst_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_dc, tx_valid, busy;
  logic        tx_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  logic [7:0] fb_model [NB];
  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  lcd_fb_streamer dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(4'hF),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_ack_o(wb_ack),
    .lcd_rst_done(lcd_rst_done),
    .tx_data(tx_data), .tx_dc(tx_dc), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy)
  );

  function automatic logic [31:0] fb_addr(input int i);
    return 32'h800 | (32'(i) << 2);
  endfunction

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    @(negedge clk);
    wb_adr = adr; wb_dat_i = dat; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    tests++;
    if (wb_ack !== 1'b1) begin
      fails++;
      $display("FAIL wb_write_ack adr=%h got=%b want=1", adr, wb_ack);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    @(negedge clk);
    wb_adr = adr; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    tests++;
    if (wb_ack !== 1'b1) begin
      fails++;
      $display("FAIL wb_read_ack adr=%h got=%b want=1", adr, wb_ack);
    end
    dat = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] adr, input logic [31:0] want);
    logic [31:0] v;
    wb_read(adr, v);
    tests++;
    if (v !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, v, want);
    end
  endtask

  task automatic build_expected(input int frames);
    exp_q.delete();
    for (int f = 0; f < frames; f++) begin
      exp_q.push_back(9'h080);
      exp_q.push_back(9'h040);
      for (int i = 0; i < NB; i++) exp_q.push_back({1'b1, fb_model[i]});
    end
  endtask

  task automatic compare_stream(input string name);
    int bad;
    int first;
    bad = 0; first = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    tests++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      fails++;
      if (first >= 0)
        $display("FAIL %s len=%0d want_len=%0d bad=%0d first@%0d got=%h want=%h",
                 name, got_q.size(), exp_q.size(), bad, first, got_q[first], exp_q[first]);
      else
        $display("FAIL %s len=%0d want_len=%0d", name, got_q.size(), exp_q.size());
    end
  endtask

  // Runs until busy rises and falls again, recording accepted bytes.
  task automatic collect(input bit rnd, input int clear_at,
                         output int start_cyc, output int busy_cyc, output int stall_err);
    logic [8:0] held;
    bit hold, started, done;
    got_q.delete();
    start_cyc = 0; busy_cyc = 0; stall_err = 0;
    hold = 1'b0; started = 1'b0; done = 1'b0; held = 9'd0;
    for (int c = 1; c <= 8000 && !done; c++) begin
      @(negedge clk);
      if (wb_cyc) begin
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      end
      if (hold && (tx_valid !== 1'b1 || {tx_dc, tx_data} !== held)) stall_err++;
      if (busy === 1'b1) begin
        if (!started) start_cyc = c;
        started = 1'b1;
        busy_cyc++;
      end else if (started) begin
        done = 1'b1;
      end
      if (!done) begin
        if (clear_at != 0 && c == clear_at) begin
          wb_adr = 32'd0; wb_dat_i = 32'd0; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        end
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_valid && tx_ready) got_q.push_back({tx_dc, tx_data});
        hold = tx_valid && !tx_ready;
        held = {tx_dc, tx_data};
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL frame_timeout started=%0d busy=%b want=frame_complete", started, busy);
    end
  endtask

  task automatic fill_fb(input bit rnd);
    for (int i = 0; i < NB; i++) begin
      fb_model[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i & 255);
      wb_write(fb_addr(i), {24'd0, fb_model[i]});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({tx_valid, tx_dc, busy, wb_ack} !== 4'b0000 || tx_data !== 8'h00 || wb_dat_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs got=v%b dc%b busy%b ack%b data%h dat%h want=all_zero",
               tx_valid, tx_dc, busy, wb_ack, tx_data, wb_dat_o);
    end
    check_reg("reset_status", 32'h4, 32'h0);
    check_reg("reset_ctrl", 32'h0, 32'h0);
    check_reg("reset_frame_cnt", 32'h8, 32'h0);
  endtask

  task automatic test_stream();
    int s, b, e;
    fill_fb(1'b0);
    lcd_rst_done = 1'b1;
    tx_ready = 1'b1;
    wb_write(32'h0, 32'h1);
    collect(1'b0, 0, s, b, e);
    build_expected(1);
    compare_stream("stream_basic");
    tests++;
    if (s != 1) begin fails++; $display("FAIL start_latency got=%0d want=1", s); end
    tests++;
    if (b != 1011) begin fails++; $display("FAIL frame_cycles got=%0d want=1011", b); end
    check_reg("frame_cnt_1", 32'h8, 32'd1);
  endtask

  task automatic test_backpressure();
    int s, b, e;
    wb_write(32'h0, 32'h1);
    collect(1'b1, 0, s, b, e);
    build_expected(1);
    compare_stream("stream_backpressure");
    tests++;
    if (e != 0) begin fails++; $display("FAIL stall_stable violations=%0d want=0", e); end
    tests++;
    if (b <= 1011) begin fails++; $display("FAIL stall_cycles got=%0d want=>1011", b); end
    check_reg("frame_cnt_2", 32'h8, 32'd2);
  endtask

  task automatic test_rst_done_gate();
    int s, b, e, vcnt;
    lcd_rst_done = 1'b0;
    tx_ready = 1'b0;
    wb_write(32'h0, 32'h1);
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || busy !== 1'b0) vcnt++;
    end
    tests++;
    if (vcnt != 0) begin fails++; $display("FAIL gated_no_start active_cycles=%0d want=0", vcnt); end
    check_reg("status_pending", 32'h4, 32'h4);
    lcd_rst_done = 1'b1;
    collect(1'b0, 0, s, b, e);
    tests++;
    if (s < 1 || s > 2) begin fails++; $display("FAIL gated_start_latency got=%0d want=1..2", s); end
    build_expected(1);
    compare_stream("stream_after_gate");
    check_reg("status_after_gate", 32'h4, 32'h2);
  endtask

  task automatic test_auto();
    int s, b, e;
    fill_fb(1'b1);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reg("frame_cnt_after_reset", 32'h8, 32'd0);
    wb_write(32'h0, 32'h3);
    collect(1'b0, 1011 + 300, s, b, e);
    build_expected(2);
    compare_stream("stream_auto_two_frames");
    tests++;
    if (b != 2022) begin fails++; $display("FAIL auto_busy_cycles got=%0d want=2022", b); end
    check_reg("auto_frame_cnt", 32'h8, 32'd2);
    check_reg("auto_cleared", 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_frame();
    int n, idx;
    logic [31:0] v;
    bit hit;
    tx_ready = 1'b1;
    wb_write(32'h0, 32'h1);
    n = 0; hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clk);
      if (tx_valid && tx_dc && tx_ready) n++;
      if (n == 200) begin
        reset = 1'b1;
        hit = 1'b1;
      end
    end
    @(negedge clk);
    tests++;
    if (!hit || tx_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_frame reached=%0d valid=%b busy=%b want=valid0_busy0", hit, tx_valid, busy);
    end
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      idx = (k == 0) ? 0 : ((k == 1) ? NB - 1 : int'($urandom_range(0, NB - 1)));
      wb_read(fb_addr(idx), v);
      tests++;
      if (v !== {24'd0, fb_model[idx]}) begin
        fails++;
        $display("FAIL fb_preserved idx=%0d got=%h want=%h", idx, v, fb_model[idx]);
      end
    end
    wb_write(fb_addr(NB), 32'hAB);
    check_reg("fb_oob_read", fb_addr(NB), 32'h0);
    wb_read(fb_addr(0), v);
    tests++;
    if (v !== {24'd0, fb_model[0]}) begin
      fails++;
      $display("FAIL fb_oob_no_alias got=%h want=%h", v, fb_model[0]);
    end
    check_reg("bad_reg_offset", 32'h14, 32'h0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_rst_done_gate();
    test_auto();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
